// File: rtl/adma_fetch_responder_if.sv
// ROM-side request/acknowledge bus of the ADMA fetch responder.
// The master drives the request and address; the ROM controller answers with ack and data.
interface adma_fetch_responder_if #(
  parameter int unsigned ROM_AW = 17
);
  logic              mem_req;
  logic [ROM_AW-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );
endinterface

// File: rtl/adma_fetch_responder.sv
// Memory-side responder for ADMA sample fetches: 2-entry request queue, CPU-gated issue,
// req/ack ROM transaction with timeout, and a one-cycle valid pulse per returned byte.
module adma_fetch_responder #(
  parameter int unsigned       ROM_AW    = 17,
  parameter logic [ROM_AW-1:0] ROM_MASK  = 17'h1FFFF,
  parameter int unsigned       TIMEOUT   = 64,
  parameter logic [7:0]        FILL_BYTE = 8'h00
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          adma_read,
  input  logic [15:0]                   adma_addr,
  input  logic [2:0]                    adma_bank,
  input  logic                          cpu_busy,
  adma_fetch_responder_if.master        mem,
  output logic [7:0]                    sample_data,
  output logic                          sample_valid,
  output logic                          timeout_flag,
  output logic [7:0]                    overrun_cnt,
  input  logic                          clr_status
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StReturn} state_e;

  state_e            state_q, state_d;
  logic [ROM_AW-1:0] fifo_q [2];
  logic [ROM_AW-1:0] fifo_d [2];
  logic [1:0]        level_q, level_d;
  logic [ROM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        timer_q, timer_d;
  logic [7:0]        sample_data_q, sample_data_d;
  logic [7:0]        overrun_q, overrun_d, overrun_base;
  logic              timeout_q, timeout_d;

  logic [16:0]       raw_addr;
  logic [ROM_AW-1:0] new_entry;
  logic              pop, push, drop, wr_idx, terminal, timeout_evt;
  logic              unused_addr_hi;

  // Bits 15:14 of the ADMA address are outside the 16 KiB bank window.
  assign unused_addr_hi = ^adma_addr[15:14];
  assign raw_addr       = {adma_bank, adma_addr[13:0]};
  assign new_entry      = ROM_AW'(raw_addr) & ROM_MASK;
  assign terminal       = (timer_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    mem_addr_d    = mem_addr_q;
    sample_data_d = sample_data_q;
    pop           = 1'b0;
    timeout_evt   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (level_q != 2'd0 && !cpu_busy) begin
          pop        = 1'b1;
          mem_addr_d = fifo_q[0];
          state_d    = StIssue;
        end
      end
      StIssue: begin
        timer_d = 8'd0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + 8'd1;
        // An ack on the terminal-count cycle takes priority over the timeout.
        if (mem.mem_ack) begin
          sample_data_d = mem.mem_data;
          state_d       = StReturn;
        end else if (terminal) begin
          sample_data_d = FILL_BYTE;
          timeout_evt   = 1'b1;
          state_d       = StReturn;
        end
      end
      StReturn: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // A pop frees the head slot before the push is placed, so a full queue can still accept.
  always_comb begin
    push      = adma_read && (level_q != 2'd2 || pop);
    drop      = adma_read && !push;
    wr_idx    = pop ? (level_q == 2'd2) : (level_q == 2'd1);
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    if (pop) fifo_d[0] = fifo_q[1];
    if (push) fifo_d[wr_idx] = new_entry;
    level_d = level_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    overrun_base = clr_status ? 8'd0 : overrun_q;
    overrun_d    = (drop && overrun_base != 8'hFF) ? overrun_base + 8'd1 : overrun_base;
    timeout_d    = (timeout_q && !clr_status) || timeout_evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      level_q       <= 2'd0;
      mem_addr_q    <= '0;
      timer_q       <= 8'd0;
      sample_data_q <= 8'd0;
      overrun_q     <= 8'd0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fifo_q[0]     <= fifo_d[0];
      fifo_q[1]     <= fifo_d[1];
      level_q       <= level_d;
      mem_addr_q    <= mem_addr_d;
      timer_q       <= timer_d;
      sample_data_q <= sample_data_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  assign mem.mem_req   = (state_q == StIssue) || (state_q == StWait);
  assign mem.mem_addr  = mem_addr_q;
  assign sample_data   = sample_data_q;
  assign sample_valid  = (state_q == StReturn);
  assign timeout_flag  = timeout_q;
  assign overrun_cnt   = overrun_q;

endmodule
